// File: rtl/id_stage_if.sv
// ---------------------------------------------------------------------------
// id_stage_if
// Bundles every non-clock/reset signal of the RV32I decode stage.
//   master : the pipeline environment (fetch, write-back, EX control).
//            It drives IF/ID, stall/flush and the write-back port, and
//            observes hazard_stall and the ID/EX register.
//   slave  : the decode stage itself (id_stage).
// Signals:
//   if_pc/if_instr/if_valid   IF/ID contents
//   stall_id/flush_id         ID/EX hold / squash requests
//   wb_we/wb_rd/wb_data       register-file write port
//   hazard_stall              load-use detected (combinational)
//   ex_*                      registered ID/EX boundary
// ---------------------------------------------------------------------------
interface id_stage_if #(
    parameter int XLEN = 32
) ();
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            if_valid;
    logic            stall_id;
    logic            flush_id;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            hazard_stall;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_val;
    logic [XLEN-1:0] ex_rs2_val;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [2:0]      ex_funct3;
    logic [3:0]      ex_alu_op;
    logic            ex_alu_src_imm;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_reg_write;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_illegal;

    modport master (
        output if_pc, if_instr, if_valid, stall_id, flush_id,
               wb_we, wb_rd, wb_data,
        input  hazard_stall, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_alu_op, ex_alu_src_imm,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
               ex_illegal
    );

    modport slave (
        input  if_pc, if_instr, if_valid, stall_id, flush_id,
               wb_we, wb_rd, wb_data,
        output hazard_stall, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_alu_op, ex_alu_src_imm,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
               ex_illegal
    );
endinterface

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// RV32I decode stage: 32x32 register file with write-to-read bypass, full
// base-ISA decode and immediate generation, load-use hazard detection and
// the registered ID/EX boundary with stall/flush control.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset; clears x0..x31 and ID/EX
//   bus    id_stage_if.slave (IF/ID in, WB port in, stall/flush in,
//          hazard_stall and ex_* out)
// ---------------------------------------------------------------------------
module id_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    id_stage_if.slave   bus
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic            alu_src_imm;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            branch;
        logic            jump;
        logic            illegal;
    } id_ex_t;

    // alt selects SUB (funct3=000) or SRA (funct3=101); callers decide when
    // funct7[5] is allowed to have that effect.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                   input logic       alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            funct7_b5;

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    logic            uses_rs1;
    logic            uses_rs2;
    logic            hazard;

    id_ex_t          dec;
    id_ex_t          ex_q;

    assign instr     = bus.if_instr;
    assign opcode    = instr[6:0];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];

    // Register file. x0 is never written, so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_we && (bus.wb_rd != 5'd0)) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Same-cycle WB bypass so an instruction decoded while its source is
    // being written captures the new value.
    always_comb begin
        rs1_val = regs[rs1];
        if (rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (bus.wb_we && (bus.wb_rd == rs1)) begin
            rs1_val = bus.wb_data;
        end
    end

    always_comb begin
        rs2_val = regs[rs2];
        if (rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (bus.wb_we && (bus.wb_rd == rs2)) begin
            rs2_val = bus.wb_data;
        end
    end

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};

    // Register indices and funct3 always pass through; immediate and all
    // control fields stay zero for formats (OP, illegal) that define none.
    always_comb begin
        dec             = '0;
        dec.valid       = 1'b1;
        dec.pc          = bus.if_pc;
        dec.rs1_val     = rs1_val;
        dec.rs2_val     = rs2_val;
        dec.rs1         = rs1;
        dec.rs2         = rs2;
        dec.rd          = instr[11:7];
        dec.funct3      = funct3;
        uses_rs1        = 1'b0;
        uses_rs2        = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.imm         = imm_u;
                dec.alu_op      = ALU_PASSB;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm         = imm_u;
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_JAL: begin
                dec.imm         = imm_j;
                dec.alu_src_imm = 1'b1;
                dec.jump        = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_JALR: begin
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.jump        = 1'b1;
                dec.reg_write   = 1'b1;
                uses_rs1        = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm         = imm_b;
                dec.branch      = 1'b1;
                uses_rs1        = 1'b1;
                uses_rs2        = 1'b1;
            end
            OPC_LOAD: begin
                dec.imm         = imm_i;
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.mem_read    = 1'b1;
                dec.reg_write   = 1'b1;
                uses_rs1        = 1'b1;
            end
            OPC_STORE: begin
                dec.imm         = imm_s;
                dec.alu_op      = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.mem_write   = 1'b1;
                uses_rs1        = 1'b1;
                uses_rs2        = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.imm         = imm_i;
                // In I-type the funct7 bits are immediate bits; only SRAI
                // gives bit 30 an opcode meaning.
                dec.alu_op      = alu_from_funct3(funct3,
                                      (funct3 == 3'b101) && funct7_b5);
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                uses_rs1        = 1'b1;
            end
            OPC_OP: begin
                dec.alu_op      = alu_from_funct3(funct3, funct7_b5);
                dec.reg_write   = 1'b1;
                uses_rs1        = 1'b1;
                uses_rs2        = 1'b1;
            end
            default: begin
                dec.illegal     = 1'b1;
            end
        endcase
    end

    // A flush kills whatever is in IF/ID this cycle, so there is nothing to
    // protect and no reason to hold the front end.
    assign hazard = bus.if_valid && ex_q.valid && ex_q.mem_read &&
                    (ex_q.rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == ex_q.rd)) ||
                     (uses_rs2 && (rs2 == ex_q.rd))) &&
                    !bus.flush_id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (bus.flush_id) begin
            ex_q <= '0;
        end else if (bus.stall_id) begin
            ex_q <= ex_q;
        end else if (hazard || !bus.if_valid) begin
            ex_q <= '0;
        end else begin
            ex_q <= dec;
        end
    end

    assign bus.hazard_stall   = hazard;
    assign bus.ex_valid       = ex_q.valid;
    assign bus.ex_pc          = ex_q.pc;
    assign bus.ex_rs1_val     = ex_q.rs1_val;
    assign bus.ex_rs2_val     = ex_q.rs2_val;
    assign bus.ex_imm         = ex_q.imm;
    assign bus.ex_rs1         = ex_q.rs1;
    assign bus.ex_rs2         = ex_q.rs2;
    assign bus.ex_rd          = ex_q.rd;
    assign bus.ex_funct3      = ex_q.funct3;
    assign bus.ex_alu_op      = ex_q.alu_op;
    assign bus.ex_alu_src_imm = ex_q.alu_src_imm;
    assign bus.ex_mem_read    = ex_q.mem_read;
    assign bus.ex_mem_write   = ex_q.mem_write;
    assign bus.ex_reg_write   = ex_q.reg_write;
    assign bus.ex_branch      = ex_q.branch;
    assign bus.ex_jump        = ex_q.jump;
    assign bus.ex_illegal     = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
// Scoreboard bench for id_stage: each cycle the expected ID/EX contents are
// queued when the stimulus is applied and compared after the clock edge.
// ---------------------------------------------------------------------------
module tb_id_stage;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SRA = 4'd7, OR_ = 4'd8,
                           PASSB = 4'd10;
    // control bit order: {alu_src_imm, mem_read, mem_write, reg_write,
    //                     branch, jump, illegal}
    localparam logic [6:0] C_SRC = 7'b1000000, C_MR = 7'b0100000,
                           C_MW  = 7'b0010000, C_RW = 7'b0001000,
                           C_BR  = 7'b0000100, C_JP = 7'b0000010,
                           C_ILL = 7'b0000001;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [6:0]  ctl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ins(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [31:0] rs1v, input logic [31:0] rs2v,
                                 input logic [31:0] imm, input logic [3:0] alu,
                                 input logic [6:0] ctl);
        exp_t e;
        e.valid = 1'b1;
        e.pc    = pc;
        e.rs1v  = rs1v;
        e.rs2v  = rs2v;
        e.imm   = imm;
        e.rs1   = instr[19:15];
        e.rs2   = instr[24:20];
        e.rd    = instr[11:7];
        e.f3    = instr[14:12];
        e.alu   = alu;
        e.ctl   = ctl;
        return e;
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e = '0;
        return e;
    endfunction

    task automatic check_ex(input string ctx);
        exp_t e;
        logic [6:0] ctl;
        check_val({ctx, ".q_size"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ctl = {bus.ex_alu_src_imm, bus.ex_mem_read, bus.ex_mem_write,
                   bus.ex_reg_write, bus.ex_branch, bus.ex_jump, bus.ex_illegal};
            check_val({ctx, ".valid"},  32'(bus.ex_valid),   32'(e.valid));
            check_val({ctx, ".pc"},     bus.ex_pc,           e.pc);
            check_val({ctx, ".rs1_val"}, bus.ex_rs1_val,     e.rs1v);
            check_val({ctx, ".rs2_val"}, bus.ex_rs2_val,     e.rs2v);
            check_val({ctx, ".imm"},    bus.ex_imm,          e.imm);
            check_val({ctx, ".rs1"},    32'(bus.ex_rs1),     32'(e.rs1));
            check_val({ctx, ".rs2"},    32'(bus.ex_rs2),     32'(e.rs2));
            check_val({ctx, ".rd"},     32'(bus.ex_rd),      32'(e.rd));
            check_val({ctx, ".funct3"}, 32'(bus.ex_funct3),  32'(e.f3));
            check_val({ctx, ".alu_op"}, 32'(bus.ex_alu_op),  32'(e.alu));
            check_val({ctx, ".ctl"},    32'(ctl),            32'(e.ctl));
        end
    endtask

    task automatic cyc(input exp_t e, input string ctx);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_ex(ctx);
    endtask

    task automatic drv(input logic [31:0] pc, input logic [31:0] instr,
                       input logic valid);
        bus.if_pc    = pc;
        bus.if_instr = instr;
        bus.if_valid = valid;
    endtask

    task automatic chk_haz(input string tag, input logic exp);
        #1;
        check_val(tag, 32'(bus.hazard_stall), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e_sub;
        rst_n        = 1'b0;
        bus.stall_id = 1'b0;
        bus.flush_id = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = '0;
        drv(32'h0, 32'h0, 1'b0);
        @(negedge clk);
        cyc(bub(), "rst0");

        // Dirty every register, then reset with a valid instruction present.
        rst_n = 1'b1;
        for (int k = 1; k < 32; k++) begin
            bus.wb_we   = 1'b1;
            bus.wb_rd   = 5'(k);
            bus.wb_data = 32'hA500_0000 | 32'(k);
            cyc(bub(), "wr_all");
        end
        bus.wb_we = 1'b0;
        rst_n = 1'b0;
        drv(32'h100, 32'h00500093, 1'b1);
        cyc(bub(), "rst1");
        cyc(bub(), "rst2");
        check_val("rst_hazard", 32'(bus.hazard_stall), 32'd0);
        rst_n = 1'b1;

        // or x3,xk,xk reads every register back as zero.
        for (int k = 1; k < 32; k++) begin
            logic [4:0]  r;
            logic [31:0] w;
            r = 5'(k);
            w = {7'b0, r, r, 3'b110, 5'd3, 7'b0110011};
            drv(32'(k * 4), w, 1'b1);
            cyc(ins(32'(k * 4), w, 32'd0, 32'd0, 32'd0, OR_, C_RW),
                $sformatf("rd0_x%0d", k));
        end

        drv(32'h100, 32'h00500093, 1'b1);
        cyc(ins(32'h100, 32'h00500093, 0, 0, 32'd5, ADD, C_SRC | C_RW), "addi");

        bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd7;
        drv(32'h104, 32'h002081B3, 1'b1);
        cyc(ins(32'h104, 32'h002081B3, 32'd7, 0, 0, ADD, C_RW), "bypass");
        bus.wb_rd = 5'd0; bus.wb_data = 32'd9;
        drv(32'h108, 32'h002001B3, 1'b1);
        cyc(ins(32'h108, 32'h002001B3, 0, 0, 0, ADD, C_RW), "bypass_x0");
        bus.wb_rd = 5'd2; bus.wb_data = 32'h22;
        drv(32'h10C, 32'h00500093, 1'b0);
        cyc(bub(), "invalid");
        bus.wb_we = 1'b0;

        drv(32'h110, 32'h002081B3, 1'b1);
        cyc(ins(32'h110, 32'h002081B3, 7, 32'h22, 0, ADD, C_RW), "rf_add");
        drv(32'h114, 32'h40208233, 1'b1);
        e_sub = ins(32'h114, 32'h40208233, 7, 32'h22, 0, SUB, C_RW);
        cyc(e_sub, "sub");
        drv(32'h118, 32'h4030D213, 1'b1);
        cyc(ins(32'h118, 32'h4030D213, 7, 0, 32'h403, SRA, C_SRC | C_RW), "srai");
        drv(32'h11C, 32'hC0008213, 1'b1);
        cyc(ins(32'h11C, 32'hC0008213, 7, 0, 32'hFFFFFC00, ADD, C_SRC | C_RW),
            "addi_neg");
        drv(32'h120, 32'h0020A423, 1'b1);
        cyc(ins(32'h120, 32'h0020A423, 7, 32'h22, 32'd8, ADD, C_SRC | C_MW), "sw");
        drv(32'h124, 32'h010000EF, 1'b1);
        cyc(ins(32'h124, 32'h010000EF, 0, 0, 32'd16, ADD, C_SRC | C_RW | C_JP),
            "jal");
        drv(32'h128, 32'h00008067, 1'b1);
        cyc(ins(32'h128, 32'h00008067, 7, 0, 0, ADD, C_SRC | C_RW | C_JP), "jalr");
        drv(32'h12C, 32'h00001297, 1'b1);
        cyc(ins(32'h12C, 32'h00001297, 0, 0, 32'h1000, ADD, C_SRC | C_RW), "auipc");
        drv(32'h130, 32'h800003B7, 1'b1);
        cyc(ins(32'h130, 32'h800003B7, 0, 0, 32'h80000000, PASSB, C_SRC | C_RW),
            "lui");
        drv(32'h134, 32'hFE208CE3, 1'b1);
        cyc(ins(32'h134, 32'hFE208CE3, 7, 32'h22, 32'hFFFFFFF8, ADD, C_BR), "beq");
        drv(32'h138, 32'h0000007F, 1'b1);
        cyc(ins(32'h138, 32'h0000007F, 0, 0, 0, ADD, C_ILL), "illegal");

        // Load followed by an instruction that does not read the load target.
        drv(32'h200, 32'h0000A283, 1'b1);
        cyc(ins(32'h200, 32'h0000A283, 7, 0, 0, ADD, C_SRC | C_MR | C_RW), "lw0");
        drv(32'h204, 32'h800002B7, 1'b1);
        chk_haz("haz_lui", 1'b0);
        cyc(ins(32'h204, 32'h800002B7, 0, 0, 32'h80000000, PASSB, C_SRC | C_RW),
            "lui_after_lw");

        // Classic load-use through rs1/rs2.
        drv(32'h208, 32'h0000A283, 1'b1);
        cyc(ins(32'h208, 32'h0000A283, 7, 0, 0, ADD, C_SRC | C_MR | C_RW), "lw1");
        drv(32'h20C, 32'h00528333, 1'b1);
        chk_haz("haz_on", 1'b1);
        cyc(bub(), "haz_bubble");
        chk_haz("haz_off", 1'b0);
        cyc(ins(32'h20C, 32'h00528333, 0, 0, 0, ADD, C_RW), "haz_add");

        // Load-use on rs2 only (store data).
        drv(32'h210, 32'h0000A283, 1'b1);
        cyc(ins(32'h210, 32'h0000A283, 7, 0, 0, ADD, C_SRC | C_MR | C_RW), "lw2");
        drv(32'h214, 32'h0050A023, 1'b1);
        chk_haz("haz_rs2", 1'b1);
        cyc(bub(), "haz_rs2_bubble");

        // Flush suppresses the hazard and squashes.
        drv(32'h218, 32'h0000A283, 1'b1);
        cyc(ins(32'h218, 32'h0000A283, 7, 0, 0, ADD, C_SRC | C_MR | C_RW), "lw3");
        drv(32'h21C, 32'h0050A023, 1'b1);
        bus.flush_id = 1'b1;
        chk_haz("haz_flush", 1'b0);
        cyc(bub(), "flush_bubble");
        bus.flush_id = 1'b0;
        chk_haz("haz_after_flush", 1'b0);
        cyc(ins(32'h21C, 32'h0050A023, 7, 0, 0, ADD, C_SRC | C_MW), "sw_after");

        // Downstream stall holds ID/EX; flush overrides stall.
        drv(32'h300, 32'h40208233, 1'b1);
        e_sub = ins(32'h300, 32'h40208233, 7, 32'h22, 0, SUB, C_RW);
        cyc(e_sub, "sub2");
        bus.stall_id = 1'b1;
        drv(32'h304, 32'hFE208CE3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(e_sub, $sformatf("stall%0d", k));
        end
        bus.flush_id = 1'b1;
        cyc(bub(), "flush_stall");
        bus.flush_id = 1'b0;
        bus.stall_id = 1'b0;

        // Reset during a load-use hazard restarts empty with cleared registers.
        drv(32'h400, 32'h0000A283, 1'b1);
        cyc(ins(32'h400, 32'h0000A283, 7, 0, 0, ADD, C_SRC | C_MR | C_RW), "lw4");
        drv(32'h404, 32'h00528333, 1'b1);
        chk_haz("haz_pre_rst", 1'b1);
        rst_n = 1'b0;
        cyc(bub(), "rst_mid_haz");
        rst_n = 1'b1;
        chk_haz("haz_post_rst", 1'b0);
        drv(32'h408, 32'h002081B3, 1'b1);
        cyc(ins(32'h408, 32'h002081B3, 0, 0, 0, ADD, C_RW), "post_rst_add");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
RV32I decode stage between the fetch stage's IF/ID output ({pc, instr, valid}) and the execute stage. It contains:
- the 32x32 architectural register file, with a WB write port and write-to-read bypass;
- full RV32I base decode and immediate generation;
- load-use hazard detection;
- the registered ID/EX pipeline boundary, with stall and flush control.

Parameters:
XLEN, 32, datapath / register width
NREGS, 32, architectural register count (index width 5)

Ports:
clk  in  1  clock
rst_n  in  1  reset
if_pc  in  32  PC of instruction in IF/ID
if_instr  in  32  instruction word in IF/ID
if_valid  in  1  IF/ID holds a real instruction
stall_id  in  1  hold ID/EX register (downstream stall)
flush_id  in  1  squash ID/EX contents (branch redirect)
wb_we  in  1  register-file write enable
wb_rd  in  5  write index
wb_data  in  32  write data
hazard_stall  out  1  combinational; load-use detected, IF and IF/ID must hold
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  32  instruction PC
ex_rs1_val  out  32  rs1 operand
ex_rs2_val  out  32  rs2 operand
ex_imm  out  32  sign-extended immediate
ex_rs1  out  5  rs1 index (for EX forwarding)
ex_rs2  out  5  rs2 index
ex_rd  out  5  destination index
ex_funct3  out  3  instr[14:12]
ex_alu_op  out  4  ALU opcode
ex_alu_src_imm  out  1  ALU B operand = imm
ex_mem_read  out  1  load
ex_mem_write  out  1  store
ex_reg_write  out  1  writes rd
ex_branch  out  1  conditional branch
ex_jump  out  1  JAL/JALR
ex_illegal  out  1  unsupported opcode

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. While rst_n=0 at a clk edge:
  - all registers x0..x31 are cleared to 0;
  - all ex_* outputs are cleared to 0.
- Register file:
  - Write occurs at posedge when wb_we=1 and wb_rd!=0.
  - x0 always reads 0.
  - Reads are combinational. If wb_we=1, wb_rd==rs and rs!=0, the read returns wb_data (same-cycle bypass).
- Decode opcodes (instr[6:0]):
  - LUI 0110111: U-imm, alu_op PASSB, reg_write
  - AUIPC 0010111: U-imm, ADD, reg_write
  - JAL 1101111: J-imm, jump, reg_write
  - JALR 1100111: I-imm, jump, reg_write
  - BRANCH 1100011: B-imm, branch
  - LOAD 0000011: I-imm, ADD, mem_read, reg_write
  - STORE 0100011: S-imm, ADD, mem_write
  - OP-IMM 0010011: I-imm, reg_write
  - OP 0110011: reg_write
  - All other opcodes: ex_illegal=1, all control bits 0, ex_valid still 1.
- Immediates: the I/S/B/U/J formats per the RV32I spec. All are sign-extended to 32 bits; B and J have bit0=0.
- ex_alu_src_imm=1 for every format except OP and BRANCH.
- alu_op encoding: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10.
  - OP: selected from funct3, plus funct7[5] selecting SUB/SRA.
  - OP-IMM: funct7[5] is honoured only for SRAI (funct3=101). ADDI never produces SUB.
- rs usage:
  - rs1 is used by every format except LUI, AUIPC and JAL.
  - rs2 is used only by BRANCH, STORE and OP.
  - Unused rs fields are still passed through unchanged.
- hazard_stall = if_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)) & !flush_id.
- ID/EX register update at posedge, in priority order:
  1. reset;
  2. flush_id -> bubble;
  3. stall_id -> hold all ex_* unchanged;
  4. hazard_stall -> bubble;
  5. if_valid=0 -> bubble;
  6. otherwise capture the decoded instruction.
- Bubble means:
  - ex_valid=0;
  - ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal = 0;
  - all other fields = 0.
- Latency: 1 cycle from IF/ID to ID/EX.
- Simultaneous WB write to a register read in the same cycle: the captured operand is the new value.
- Reset asserted mid-stall or mid-hazard: reset wins, and the stage restarts empty.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with if_valid=1 -> all ex_*=0, hazard_stall=0; x1..x31 read 0.
- addi x1,x0,5 (0x00500093), if_pc=0x100 -> next cycle:
  - ex_valid=1, ex_pc=0x100, ex_rd=1, ex_imm=5, alu_op=0;
  - alu_src_imm=1, reg_write=1, ex_rs1_val=0.
- Bypass: wb_we=1, wb_rd=1, wb_data=7, with add x3,x1,x2 (0x002081B3) in IF/ID -> ex_rs1_val=7. Same with wb_rd=0 -> x0 stays 0.
- Load-use: cycle N lw x5,0(x1) (0x0000A283); cycle N+1 add x6,x5,x5 (0x00528333):
  - N+1: hazard_stall=1;
  - N+2: ex_valid=0 (bubble), hazard_stall=0;
  - N+3: the add is captured with ex_rd=6.
- beq x1,x2,-8 (0xFE208CE3) -> ex_branch=1, ex_imm=0xFFFFFFF8, alu_src_imm=0, reg_write=0.
- Control priority:
  - stall_id=1 for 3 cycles -> ex_* unchanged.
  - flush_id=1 together with stall_id=1 -> ex_valid=0 next cycle.
  - instr 0x0000007F -> ex_illegal=1, ex_valid=1, all controls 0.
